// File: rtl/freqdetector.sv
// freqdetector: measures the fundamental of a signed sample stream and outputs the phase increment that regenerates it
//  lrclk  : sample clock, one sample per rising edge
//  reset  : synchronous, active-high
//  in     : signed BITSIZE-bit sample
//  freq   : last computed increment, floor(2^PHASESIZE / period)
//  valid  : one-cycle pulse when freq updates
//  locked : high while measurements are current
module freqdetector #(
  parameter int BITSIZE    = 24,
  parameter int PHASESIZE  = 16,
  parameter int PERIODSIZE = 16,
  parameter int HYST       = 256
) (
  input  logic                      lrclk,
  input  logic                      reset,
  input  logic signed [BITSIZE-1:0] in,
  output logic [PHASESIZE-1:0]      freq,
  output logic                      valid,
  output logic                      locked
);
  localparam int IW = $clog2(PHASESIZE + 2);
  localparam logic [PERIODSIZE-1:0] CMAX = '1;
  localparam logic signed [BITSIZE-1:0] HI = BITSIZE'(HYST);
  localparam logic signed [BITSIZE-1:0] LO = -HI;
  typedef enum logic {WAIT_NEG, WAIT_POS} xstate_t;
  typedef enum logic [1:0] {IDLE, DIV, DONE} dstate_t;
  xstate_t xs;
  dstate_t ds;
  logic [PERIODSIZE-1:0] cnt, dvs, pend, rem;
  logic [PHASESIZE:0] num, q;
  logic [IW-1:0] iter;
  logic prior, pend_full, stale, rise, meas, fit;
  logic [PERIODSIZE:0] trial;
  assign rise  = xs == WAIT_POS && in >= HI;
  assign meas  = rise && prior && cnt != CMAX;
  assign trial = {rem, num[PHASESIZE]};
  assign fit   = trial >= {1'b0, dvs};
  always_ff @(posedge lrclk) begin
    if (reset) begin
      xs        <= WAIT_NEG;
      ds        <= IDLE;
      cnt       <= '0;
      dvs       <= '0;
      pend      <= '0;
      rem       <= '0;
      num       <= '0;
      q         <= '0;
      iter      <= '0;
      prior     <= 1'b0;
      pend_full <= 1'b0;
      stale     <= 1'b0;
      freq      <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (xs == WAIT_NEG && in <= LO) xs <= WAIT_POS;
      else if (rise) xs <= WAIT_NEG;
      if (rise) begin
        cnt   <= PERIODSIZE'(1);
        prior <= 1'b1;
      end else if (cnt != CMAX) cnt <= cnt + 1'b1;
      case (ds)
        IDLE: if (meas || pend_full) begin
          dvs       <= meas ? cnt : pend;
          rem       <= '0;
          q         <= '0;
          num       <= {1'b1, {PHASESIZE{1'b0}}};
          iter      <= IW'(PHASESIZE);
          pend_full <= 1'b0;
          ds        <= DIV;
        end
        DIV: begin
          rem  <= fit ? PERIODSIZE'(trial - {1'b0, dvs}) : trial[PERIODSIZE-1:0];
          q    <= {q[PHASESIZE-1:0], fit};
          num  <= num << 1;
          iter <= iter - 1'b1;
          if (iter == '0) ds <= DONE;
        end
        DONE: begin
          freq   <= q[PHASESIZE-1:0];
          valid  <= 1'b1;
          locked <= !stale;
          if (pend_full) begin
            dvs       <= pend;
            rem       <= '0;
            q         <= '0;
            num       <= {1'b1, {PHASESIZE{1'b0}}};
            iter      <= IW'(PHASESIZE);
            pend_full <= 1'b0;
            ds        <= DIV;
          end else ds <= IDLE;
        end
        default: ds <= IDLE;
      endcase
      // a measurement arriving while the divider is occupied replaces any older waiting one
      if (meas && ds != IDLE) begin
        pend      <= cnt;
        pend_full <= 1'b1;
      end
      if (meas) stale <= 1'b0;
      // counter about to saturate: the next edge can no longer form a valid period
      if (!rise && cnt == CMAX - 1'b1) begin
        prior  <= 1'b0;
        locked <= 1'b0;
        stale  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_freqdetector.sv
// tb_freqdetector: directed and random tones checked cycle by cycle against a time-based reference model
module tb_freqdetector;
  localparam int BITSIZE = 24, PHASESIZE = 16, PERIODSIZE = 16, HYST = 256;
  localparam int LAT = PHASESIZE + 2;
  localparam int SATN = (1 << PERIODSIZE) - 2;
  logic lrclk = 1'b0;
  logic reset = 1'b1;
  logic signed [BITSIZE-1:0] in = '0;
  logic [PHASESIZE-1:0] freq;
  logic valid, locked;
  int passed = 0, total = 0, t = 0;
  bit armed, have_last, stale, busy, pend_full, m_valid, m_locked;
  int last_t, done_t, job_p, pend_p, m_freq;
  freqdetector #(.BITSIZE(BITSIZE), .PHASESIZE(PHASESIZE), .PERIODSIZE(PERIODSIZE), .HYST(HYST)) dut (
    .lrclk(lrclk), .reset(reset), .in(in), .freq(freq), .valid(valid), .locked(locked)
  );
  always #5 lrclk = ~lrclk;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s at cycle %0d: got %0d expected %0d", tag, t, obs, exp);
  endtask
  function automatic void m_reset();
    armed = 0; have_last = 0; stale = 0; busy = 0; pend_full = 0;
    m_valid = 0; m_locked = 0; m_freq = 0;
    last_t = t + 1;
  endfunction
  function automatic void m_step(int s);
    bit rise, meas, was_busy;
    int per;
    rise = armed && s >= HYST;
    if (!armed && s <= -HYST) armed = 1;
    else if (rise) armed = 0;
    per = t - last_t;
    meas = rise && have_last && per <= SATN;
    m_valid = 0;
    was_busy = busy;
    if (busy && t == done_t) begin
      m_valid = 1;
      m_freq = (1 << PHASESIZE) / job_p;
      m_locked = !stale;
      if (pend_full) begin
        job_p = pend_p; done_t = t + LAT; pend_full = 0;
      end else busy = 0;
    end else if (!busy && (meas || pend_full)) begin
      job_p = meas ? per : pend_p; done_t = t + LAT; busy = 1; pend_full = 0;
    end
    if (meas && was_busy) begin
      pend_p = per; pend_full = 1;
    end
    if (meas) stale = 0;
    if (rise) begin
      have_last = 1; last_t = t;
    end else if (t - last_t == SATN) begin
      have_last = 0; m_locked = 0; stale = 1;
    end
  endfunction
  task automatic step(int s);
    in = BITSIZE'(s);
    @(posedge lrclk);
    t++;
    m_step(s);
    #1;
    check("valid", {31'd0, valid}, {31'd0, m_valid});
    check("freq", {16'd0, freq}, m_freq);
    check("locked", {31'd0, locked}, {31'd0, m_locked});
  endtask
  task automatic do_reset(int n);
    reset = 1'b1;
    repeat (n) begin
      @(posedge lrclk);
      t++;
    end
    m_reset();
    #1;
    reset = 1'b0;
    check("reset_freq", {16'd0, freq}, 0);
    check("reset_valid", {31'd0, valid}, 0);
    check("reset_locked", {31'd0, locked}, 0);
  endtask
  task automatic square(int per, int from, int to, int amp);
    for (int i = from; i < to; i++) step((i % per) < per / 2 ? -amp : amp);
  endtask
  initial begin
    do_reset(3);
    square(64, 0, 256, 1000);
    check("t1_freq", {16'd0, freq}, 1024);
    check("t1_locked", {31'd0, locked}, 1);
    square(2, 0, 80, 1000);
    check("t2_freq", {16'd0, freq}, 32768);
    check("t2_locked", {31'd0, locked}, 1);
    square(100, 0, 300, 1000);
    check("t3_freq100", {16'd0, freq}, 655);
    square(50, 0, 150, 1000);
    check("t3_freq50", {16'd0, freq}, 1310);
    do_reset(2);
    for (int i = 0; i < 300; i++) step($rtoi(200.0 * $sin(6.2831853 * i / 37.0)));
    check("t4_freq", {16'd0, freq}, 0);
    check("t4_locked", {31'd0, locked}, 0);
    square(64, 0, 192, 1000);
    check("t5_lock", {31'd0, locked}, 1);
    for (int i = 0; i < 65600; i++) step(0);
    check("t5_unlocked", {31'd0, locked}, 0);
    check("t5_hold", {16'd0, freq}, 1024);
    square(64, 0, 114, 1000);
    check("t5_one_edge", {31'd0, locked}, 0);
    square(64, 114, 192, 1000);
    check("t5_relock", {31'd0, locked}, 1);
    do_reset(2);
    square(64, 0, 101, 1000);
    do_reset(5);
    square(64, 0, 256, 1000);
    check("t6_freq", {16'd0, freq}, 1024);
    check("t6_locked", {31'd0, locked}, 1);
    square(10, 0, 60, 255);
    check("hyst_below", {16'd0, freq}, 1024);
    square(10, 0, 60, 256);
    check("hyst_at", {16'd0, freq}, 6553);
    for (int k = 0; k < 25; k++) begin
      int per, amp;
      per = $urandom_range(2, 400);
      amp = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : $urandom_range(256, 8000000);
      square(per, 0, $urandom_range(per, 4 * per + 40), amp);
    end
    for (int i = 0; i < 300; i++) step(int'($urandom_range(0, 16777215)) - 8388608);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
